// File: rtl/npc_ctrl_pkg.sv
// rtl/npc_ctrl_pkg.sv - shared states, opcodes and immediate-format encodings for the NPC sequencer
package npc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_REQ,
    ST_FETCH_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STORE,
    CLS_SYS,
    CLS_ILL
  } inst_class_e;

endpackage

// File: rtl/ysyx_24100027_opdec.sv
// rtl/ysyx_24100027_opdec.sv - combinational opcode classifier feeding the control sequencer
module ysyx_24100027_opdec
  import npc_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] HALT_INST = 32'h0010_0073
) (
  input  logic [XLEN-1:0] i_inst,
  output logic [2:0]      o_extop,
  output inst_class_e     o_cls,
  output logic            o_rf_we,
  output logic            o_is_store,
  output logic            o_is_halt,
  output logic            o_is_illegal
);

  always_comb begin
    o_extop      = EXT_I;
    o_cls        = CLS_ILL;
    o_rf_we      = 1'b0;
    o_is_store   = 1'b0;
    o_is_halt    = 1'b0;
    o_is_illegal = 1'b0;
    case (i_inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        o_extop = EXT_U;
        o_cls   = CLS_ALU;
        o_rf_we = 1'b1;
      end
      OPC_JAL: begin
        o_extop = EXT_J;
        o_cls   = CLS_JUMP;
        o_rf_we = 1'b1;
      end
      OPC_JALR: begin
        o_cls   = CLS_JUMP;
        o_rf_we = 1'b1;
      end
      OPC_BRANCH: begin
        o_extop = EXT_B;
        o_cls   = CLS_BRANCH;
      end
      OPC_LOAD: begin
        o_cls   = CLS_LOAD;
        o_rf_we = 1'b1;
      end
      OPC_STORE: begin
        o_extop    = EXT_S;
        o_cls      = CLS_STORE;
        o_is_store = 1'b1;
      end
      OPC_OPIMM, OPC_OP: begin
        o_cls   = CLS_ALU;
        o_rf_we = 1'b1;
      end
      OPC_SYSTEM: begin
        // Only the exact ebreak encoding is supported; other SYSTEM forms are illegal.
        if (i_inst == HALT_INST) begin
          o_cls     = CLS_SYS;
          o_is_halt = 1'b1;
        end else begin
          o_is_illegal = 1'b1;
        end
      end
      default: o_is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_24100027_ctrl_fsm.sv
// rtl/ysyx_24100027_ctrl_fsm.sv - multi-cycle fetch/decode/mem/writeback sequencer for the NPC core
// Optional performance counters are built when NPC_PERF_CNT_EN is defined.
module ysyx_24100027_ctrl_fsm
  import npc_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] HALT_INST = 32'h0010_0073
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  input  logic            ifu_resp_valid,
  input  logic [XLEN-1:0] ifu_resp_inst,
  output logic [XLEN-1:0] inst_q,
  output logic [2:0]      extop,
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  output logic            lsu_req_wen,
  input  logic            lsu_resp_valid,
  output logic            rf_wen,
  output logic            pc_we,
  output logic            halt,
  output logic            illegal,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
);

  state_e          r_state;
  state_e          w_nxt;
  logic [XLEN-1:0] r_inst;
  logic            r_ifu_req_valid, r_lsu_req_valid, r_lsu_req_wen;
  logic            r_rf_wen, r_pc_we, r_halt, r_illegal;

  logic [2:0]      w_extop;
  inst_class_e     w_cls;
  logic            w_rf_we, w_is_store, w_is_halt, w_is_illegal, w_is_mem;

  ysyx_24100027_opdec #(
    .XLEN      (XLEN),
    .HALT_INST (HALT_INST)
  ) u_opdec (
    .i_inst       (r_inst),
    .o_extop      (w_extop),
    .o_cls        (w_cls),
    .o_rf_we      (w_rf_we),
    .o_is_store   (w_is_store),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  assign w_is_mem = (w_cls == CLS_LOAD) || (w_cls == CLS_STORE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:       w_nxt = ST_FETCH_REQ;
      ST_FETCH_REQ:  if (ifu_req_ready) w_nxt = ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (ifu_resp_valid) w_nxt = ST_DECODE;
      ST_DECODE:     w_nxt = (w_is_halt || w_is_illegal) ? ST_HALT : ST_EXEC;
      ST_EXEC:       w_nxt = w_is_mem ? ST_MEM_REQ : ST_WB;
      ST_MEM_REQ:    if (lsu_req_ready) w_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT:   if (lsu_resp_valid) w_nxt = ST_WB;
      ST_WB:         w_nxt = ST_FETCH_REQ;
      default:       w_nxt = ST_HALT;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_inst          <= '0;
      r_ifu_req_valid <= 1'b0;
      r_lsu_req_valid <= 1'b0;
      r_lsu_req_wen   <= 1'b0;
      r_rf_wen        <= 1'b0;
      r_pc_we         <= 1'b0;
      r_halt          <= 1'b0;
      r_illegal       <= 1'b0;
    end else begin
      r_state         <= w_nxt;
      r_ifu_req_valid <= (w_nxt == ST_FETCH_REQ);
      r_lsu_req_valid <= (w_nxt == ST_MEM_REQ);
      r_lsu_req_wen   <= (w_nxt == ST_MEM_REQ) && w_is_store;
      r_pc_we         <= (w_nxt == ST_WB);
      r_rf_wen        <= (w_nxt == ST_WB) && w_rf_we;
      r_halt          <= (w_nxt == ST_HALT);
      if (r_state == ST_FETCH_WAIT && ifu_resp_valid) r_inst <= ifu_resp_inst;
      if (r_state == ST_DECODE && w_is_illegal) r_illegal <= 1'b1;
    end
  end

  assign ifu_req_valid = r_ifu_req_valid;
  assign inst_q        = r_inst;
  assign lsu_req_valid = r_lsu_req_valid;
  assign lsu_req_wen   = r_lsu_req_wen;
  assign rf_wen        = r_rf_wen;
  assign pc_we         = r_pc_we;
  assign halt          = r_halt;
  assign illegal       = r_illegal;
  assign extop         = (r_state == ST_DECODE || r_state == ST_EXEC || r_state == ST_MEM_REQ ||
                          r_state == ST_MEM_WAIT || r_state == ST_WB) ? w_extop : EXT_I;

`ifdef NPC_PERF_CNT_EN
  logic [63:0] r_perf_cycle, r_perf_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycle   <= '0;
      r_perf_instret <= '0;
    end else begin
      if (r_state != ST_IDLE && r_state != ST_HALT) r_perf_cycle <= r_perf_cycle + 64'd1;
      if (r_state == ST_WB) r_perf_instret <= r_perf_instret + 64'd1;
    end
  end

  assign perf_cycle   = r_perf_cycle;
  assign perf_instret = r_perf_instret;
`else
  assign perf_cycle   = '0;
  assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_ysyx_24100027_ctrl_fsm.sv
// tb/tb_ysyx_24100027_ctrl_fsm.sv - directed table-driven bench for the NPC control sequencer
module tb_ysyx_24100027_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_resp_inst, inst_q;
  logic [2:0]  extop;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
  logic        rf_wen, pc_we, halt, illegal;
  logic [63:0] perf_cycle, perf_instret;

  ysyx_24100027_ctrl_fsm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_inst  (ifu_resp_inst),
    .inst_q         (inst_q),
    .extop          (extop),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_resp_valid (lsu_resp_valid),
    .rf_wen         (rf_wen),
    .pc_we          (pc_we),
    .halt           (halt),
    .illegal        (illegal),
    .perf_cycle     (perf_cycle),
    .perf_instret   (perf_instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int          stall;
    logic [2:0]  ext;
    logic        rf;
    int          lat;
    int          lsu_n;
    logic        wen;
    string       name;
  } vec_t;

  vec_t vt[10];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] inst, input int stall, input logic [2:0] ext,
                         input logic rf, input int lat, input int lsu_n, input logic wen, input string name);
    vt[i].inst = inst;  vt[i].stall = stall; vt[i].ext = ext; vt[i].rf = rf;
    vt[i].lat = lat;    vt[i].lsu_n = lsu_n; vt[i].wen = wen; vt[i].name = name;
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0; ifu_resp_inst = '0;
    lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ifu_req_valid"}, ifu_req_valid, 0);
    chk({tag, " lsu_req_valid"}, lsu_req_valid, 0);
    chk({tag, " lsu_req_wen"}, lsu_req_wen, 0);
    chk({tag, " rf_wen"}, rf_wen, 0);
    chk({tag, " pc_we"}, pc_we, 0);
    chk({tag, " halt"}, halt, 0);
    chk({tag, " illegal"}, illegal, 0);
    chk({tag, " inst_q"}, inst_q, 0);
    chk({tag, " extop"}, extop, 0);
    chk({tag, " perf_cycle"}, perf_cycle, 0);
    chk({tag, " perf_instret"}, perf_instret, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
  endtask

  // Plays a zero-wait memory (plus optional LSU stall) for one instruction; cycle 1 is FETCH_REQ.
  task automatic run_inst(input logic [31:0] inst, input int stall, output int lat, output logic [2:0] ext_dec,
                          output logic rf_wb, output int lsu_n, output logic wen_seen, output logic [2:0] ext_fetch);
    int   cyc, st;
    logic acc_f, acc_m;
    cyc = 0; st = stall; acc_f = 0; acc_m = 0;
    lat = 0; ext_dec = '1; rf_wb = 0; lsu_n = 0; wen_seen = 0; ext_fetch = '1;
    for (int k = 0; k < 10 && !ifu_req_valid; k++) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      cyc++;
      clear_inputs();
      if (acc_f) begin ifu_resp_valid = 1'b1; ifu_resp_inst = inst; acc_f = 0; end
      if (ifu_req_valid) begin ifu_req_ready = 1'b1; acc_f = 1; ext_fetch = extop; end
      if (acc_m) begin lsu_resp_valid = 1'b1; acc_m = 0; end
      if (lsu_req_valid) begin
        lsu_n++;
        wen_seen = wen_seen | lsu_req_wen;
        if (st > 0) st--;
        else begin lsu_req_ready = 1'b1; acc_m = 1; end
      end
      if (cyc == 3) ext_dec = extop;
      if (pc_we) begin lat = cyc; rf_wb = rf_wen; break; end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic fetch_only(input logic [31:0] inst);
    for (int k = 0; k < 10 && !ifu_req_valid; k++) @(negedge clk);
    chk("fetch request seen", ifu_req_valid, 1);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0; ifu_resp_valid = 1'b1; ifu_resp_inst = inst;
    @(negedge clk);
    ifu_resp_valid = 1'b0;
  endtask

  task automatic halt_seq(input logic [31:0] inst, input logic exp_ill, input string tag);
    int        n_req, n_pc, n_rf;
    logic [63:0] pc0;
    n_req = 0; n_pc = 0; n_rf = 0;
    fetch_only(inst);
    chk({tag, " inst_q"}, inst_q, inst);
    n_pc += pc_we; n_rf += rf_wen;
    @(negedge clk);
    chk({tag, " halt"}, halt, 1);
    chk({tag, " illegal"}, illegal, exp_ill);
    pc0 = perf_cycle;
    for (int k = 0; k < 20; k++) begin
      n_req += ifu_req_valid; n_pc += pc_we; n_rf += rf_wen;
      @(negedge clk);
    end
    chk({tag, " fetches after halt"}, n_req, 0);
    chk({tag, " pc_we pulses"}, n_pc, 0);
    chk({tag, " rf_wen pulses"}, n_rf, 0);
    chk({tag, " perf_cycle frozen"}, perf_cycle, pc0);
    chk({tag, " halt sticky"}, halt, 1);
    chk({tag, " extop in halt"}, extop, 0);
  endtask

  int         lat, lsu_n;
  logic [2:0] ed, ef;
  logic       rfw, wen;

  initial begin
    set_vec(0, 32'h00500093, 0, 3'b000, 1'b1, 5, 0, 1'b0, "addi");
    set_vec(1, 32'h123450b7, 0, 3'b001, 1'b1, 5, 0, 1'b0, "lui");
    set_vec(2, 32'h00001117, 0, 3'b001, 1'b1, 5, 0, 1'b0, "auipc");
    set_vec(3, 32'h008000ef, 0, 3'b100, 1'b1, 5, 0, 1'b0, "jal");
    set_vec(4, 32'h00208463, 0, 3'b011, 1'b0, 5, 0, 1'b0, "beq");
    set_vec(5, 32'h0000a103, 0, 3'b000, 1'b1, 7, 1, 1'b0, "lw");
    set_vec(6, 32'h00112023, 3, 3'b010, 1'b0, 10, 4, 1'b1, "sw_stall3");
    set_vec(7, 32'h000080e7, 0, 3'b000, 1'b1, 5, 0, 1'b0, "jalr");
    set_vec(8, 32'h002081b3, 0, 3'b000, 1'b1, 5, 0, 1'b0, "add");
    set_vec(9, 32'h0000a103, 2, 3'b000, 1'b1, 9, 3, 1'b0, "lw_stall2");

    do_reset();
    chk_quiet("reset");
    rst_n = 1'b1;
    chk("req before first edge", ifu_req_valid, 0);
    @(negedge clk);
    chk("req one cycle after release", ifu_req_valid, 1);

    for (int i = 0; i < 10; i++) begin
      run_inst(vt[i].inst, vt[i].stall, lat, ed, rfw, lsu_n, wen, ef);
      chk({vt[i].name, " latency"}, lat, vt[i].lat);
      chk({vt[i].name, " extop decode"}, ed, vt[i].ext);
      chk({vt[i].name, " rf_wen wb"}, rfw, vt[i].rf);
      chk({vt[i].name, " lsu_req cycles"}, lsu_n, vt[i].lsu_n);
      chk({vt[i].name, " lsu_req_wen"}, wen, vt[i].wen);
      chk({vt[i].name, " extop in fetch"}, ef, 0);
    end

    halt_seq(32'h00100073, 1'b0, "ebreak");
`ifdef NPC_PERF_CNT_EN
    chk("perf_instret after table", perf_instret, 10);
`else
    chk("perf_instret tied", perf_instret, 0);
    chk("perf_cycle tied", perf_cycle, 0);
`endif

    do_reset();
    rst_n = 1'b1;
    halt_seq(32'h0000007f, 1'b1, "illegal_opc");

    do_reset();
    rst_n = 1'b1;
    halt_seq(32'h00200073, 1'b1, "system_not_ebreak");

    // Reset mid-fetch, then a late response must not be captured.
    do_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst fetch_req", ifu_req_valid, 1);
    ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu_req_ready = 1'b0;
    chk("midrst in fetch_wait", ifu_req_valid, 0);
    rst_n = 1'b0;
    #1;
    chk_quiet("async reset");
    @(negedge clk);
    ifu_resp_valid = 1'b1; ifu_resp_inst = 32'h0000007f;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst req", ifu_req_valid, 1);
    chk("late resp ignored", inst_q, 0);
    @(negedge clk);
    chk("req held without ready", ifu_req_valid, 1);
    chk("stray resp ignored", inst_q, 0);
    ifu_resp_valid = 1'b0;
    run_inst(32'h00500093, 0, lat, ed, rfw, lsu_n, wen, ef);
    chk("clean fetch latency", lat, 5);
    chk("clean fetch rf_wen", rfw, 1);
    chk("clean fetch inst_q", inst_q, 32'h00500093);
    chk("clean fetch illegal", illegal, 0);
    chk("clean fetch halt", halt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
